// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the control sequencer.
//   state_t       one-hot FSM encoding (FETCH, DECODE, READ, WAIT_MEM, EXEC, HALT)
//   OP_*          opcode values (opcode field = instr[IW-1 -: OPW])
//   MDRS_*        MDR input select values
//   OPS_*         ALU operand select values
package ctrl_pkg;

   typedef enum logic [5:0] {
      ST_FETCH    = 6'b000001,
      ST_DECODE   = 6'b000010,
      ST_READ     = 6'b000100,
      ST_WAIT_MEM = 6'b001000,
      ST_EXEC     = 6'b010000,
      ST_HALT     = 6'b100000
   } state_t;

   localparam logic [2:0] OP_ALU = 3'b000;
   localparam logic [2:0] OP_LD  = 3'b001;
   localparam logic [2:0] OP_ST  = 3'b010;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_HLT = 3'b111;

   localparam logic [1:0] MDRS_IMM = 2'd0;
   localparam logic [1:0] MDRS_RAM = 2'd1;
   localparam logic [1:0] MDRS_ALU = 2'd2;

   localparam logic [1:0] OPS_R0  = 2'd0;
   localparam logic [1:0] OPS_R1  = 2'd1;
   localparam logic [1:0] OPS_MDR = 2'd2;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: datapath-facing signals of the control sequencer.
//   instr, mem_ready                      datapath -> sequencer
//   *_LOAD, INCR_PC                       load strobes, active high
//   REGR0S/REGR1S/REGWS, MDRS, OP0S/OP1S  bus selects
//   IRimm                                 extended immediate
//   halted, illegal                       status
// Handshake: mem_ready is sampled level-wise; a RAM access in progress
// completes in the cycle where mem_ready is high, and the sequencer advances
// on that same clock edge. No back-pressure exists in the other direction.
// Modports: master = sequencer, slave = datapath.
interface ctrl_sequencer_if #(
   parameter int IW  = 16,
   parameter int RSW = 3,
   parameter int DW  = 16
);
   logic [IW-1:0]  instr;
   logic           mem_ready;
   logic           MAR_LOAD, IR_LOAD, MDR_LOAD, REG_LOAD, RAM_LOAD, INCR_PC;
   logic [RSW-1:0] REGR0S, REGR1S, REGWS;
   logic [1:0]     MDRS, OP0S, OP1S;
   logic [DW-1:0]  IRimm;
   logic           halted, illegal;

   modport master (
      input  instr, mem_ready,
      output MAR_LOAD, IR_LOAD, MDR_LOAD, REG_LOAD, RAM_LOAD, INCR_PC,
      output REGR0S, REGR1S, REGWS, MDRS, OP0S, OP1S, IRimm, halted, illegal
   );

   modport slave (
      output instr, mem_ready,
      input  MAR_LOAD, IR_LOAD, MDR_LOAD, REG_LOAD, RAM_LOAD, INCR_PC,
      input  REGR0S, REGR1S, REGWS, MDRS, OP0S, OP1S, IRimm, halted, illegal
   );
endinterface

// File: rtl/ctrl_imm_ext.sv
// ctrl_imm_ext: widens the instruction immediate to DW bits.
//   imm  in  IMMW  raw immediate field
//   ext  out DW    sign-extended (IMM_SEXT=1) or zero-extended (IMM_SEXT=0)
module ctrl_imm_ext #(
   parameter int IMMW     = 10,
   parameter int DW       = 16,
   parameter bit IMM_SEXT = 1'b1
) (
   input  logic [IMMW-1:0] imm,
   output logic [DW-1:0]   ext
);
   assign ext = IMM_SEXT ? DW'($signed(imm)) : DW'(imm);
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction decoder and control FSM for the microcoded
// datapath. FETCH -> DECODE -> [READ -> [WAIT_MEM]] -> EXEC -> FETCH, plus HALT.
//   clk        rising-edge clock
//   reset      asynchronous, active high
//   bus        ctrl_sequencer_if.master (instr/mem_ready in, strobes/selects out)
//   dbg_state  current FSM state
// The state register is the only flop; every output is decoded from state,
// instr and mem_ready. instr must stay stable from DECODE through EXEC.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int IW       = 16,
   parameter int OPW      = 3,
   parameter int RSW      = 3,
   parameter int DW       = 16,
   parameter bit IMM_SEXT = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   ctrl_sequencer_if.master    bus,
   output state_t              dbg_state
);
   localparam int IMMW = IW - OPW - RSW;
   localparam logic [RSW-1:0] PC_IDX = {RSW{1'b1}};

   state_t state, next_state;

   logic [OPW-1:0]  op;
   logic [RSW-1:0]  tgt, rb, ra;
   logic [IMMW-1:0] imm;
   logic [DW-1:0]   imm_ext;

   logic           mar_load, ir_load, mdr_load, reg_load, ram_load, incr_pc;
   logic [RSW-1:0] r0s, r1s, ws;
   logic [1:0]     mdrs, op0s, op1s;
   logic           halted, illegal;

   assign op  = bus.instr[IW-1 -: OPW];
   assign tgt = bus.instr[RSW-1:0];
   assign rb  = bus.instr[2*RSW-1:RSW];
   assign ra  = bus.instr[3*RSW-1:2*RSW];
   assign imm = bus.instr[IW-OPW-1:RSW];

   ctrl_imm_ext #(.IMMW(IMMW), .DW(DW), .IMM_SEXT(IMM_SEXT)) u_imm_ext (
      .imm (imm),
      .ext (imm_ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = ST_FETCH;
      mar_load = 1'b0; ir_load = 1'b0; mdr_load = 1'b0;
      reg_load = 1'b0; ram_load = 1'b0; incr_pc = 1'b0;
      r0s = '0; r1s = '0; ws = '0;
      mdrs = MDRS_IMM; op0s = OPS_R0; op1s = OPS_R0;
      halted = 1'b0; illegal = 1'b0;
      // Outputs are held at default while reset is high so that a reset
      // arriving mid-instruction kills strobes in the same cycle.
      if (!reset) begin
         case (state)
            ST_FETCH: begin
               r1s = PC_IDX; op1s = OPS_R1; mar_load = 1'b1;
               if (bus.mem_ready) begin
                  ir_load = 1'b1; incr_pc = 1'b1; next_state = ST_DECODE;
               end else begin
                  next_state = ST_FETCH;
               end
            end
            ST_DECODE: begin
               case (op)
                  OPW'(OP_ALU): begin
                     r0s = ra; r1s = rb; op0s = OPS_R0; op1s = OPS_R1;
                     next_state = ST_READ;
                  end
                  OPW'(OP_LD), OPW'(OP_ST): begin
                     r0s = ra; op0s = OPS_R0; mar_load = 1'b1;
                     next_state = ST_READ;
                  end
                  OPW'(OP_LDI): begin
                     mdrs = MDRS_IMM; mdr_load = 1'b1;
                     next_state = ST_EXEC;
                  end
                  OPW'(OP_HLT): next_state = ST_HALT;
                  default: begin
                     illegal = 1'b1; next_state = ST_FETCH;
                  end
               endcase
            end
            ST_READ: begin
               case (op)
                  OPW'(OP_ALU): begin
                     r0s = ra; r1s = rb; op0s = OPS_R0; op1s = OPS_R1;
                     mdrs = MDRS_ALU; mdr_load = 1'b1; next_state = ST_EXEC;
                  end
                  OPW'(OP_ST): begin
                     // Store data (tgt register) passes through the ALU into MDR.
                     r0s = tgt; op0s = OPS_R0;
                     mdrs = MDRS_ALU; mdr_load = 1'b1; next_state = ST_EXEC;
                  end
                  OPW'(OP_LD): begin
                     mdrs = MDRS_RAM;
                     if (bus.mem_ready) begin
                        mdr_load = 1'b1; next_state = ST_EXEC;
                     end else begin
                        next_state = ST_WAIT_MEM;
                     end
                  end
                  default: next_state = ST_FETCH;
               endcase
            end
            ST_WAIT_MEM: begin
               mdrs = MDRS_RAM;
               if (bus.mem_ready) begin
                  mdr_load = 1'b1; next_state = ST_EXEC;
               end else begin
                  next_state = ST_WAIT_MEM;
               end
            end
            ST_EXEC: begin
               case (op)
                  OPW'(OP_ALU), OPW'(OP_LD), OPW'(OP_LDI): begin
                     op0s = OPS_MDR; op1s = OPS_R0; ws = tgt; reg_load = 1'b1;
                     next_state = ST_FETCH;
                  end
                  OPW'(OP_ST): begin
                     ram_load = 1'b1;
                     next_state = bus.mem_ready ? ST_FETCH : ST_EXEC;
                  end
                  default: next_state = ST_FETCH;
               endcase
            end
            ST_HALT: begin
               halted = 1'b1; next_state = ST_HALT;
            end
            default: next_state = ST_FETCH;
         endcase
      end
   end

   assign bus.MAR_LOAD = mar_load;
   assign bus.IR_LOAD  = ir_load;
   assign bus.MDR_LOAD = mdr_load;
   assign bus.REG_LOAD = reg_load;
   assign bus.RAM_LOAD = ram_load;
   assign bus.INCR_PC  = incr_pc;
   assign bus.REGR0S   = r0s;
   assign bus.REGR1S   = r1s;
   assign bus.REGWS    = ws;
   assign bus.MDRS     = mdrs;
   assign bus.OP0S     = op0s;
   assign bus.OP1S     = op1s;
   assign bus.IRimm    = (op == OPW'(OP_LDI)) ? imm_ext : '0;
   assign bus.halted   = halted;
   assign bus.illegal  = illegal;
   assign dbg_state    = state;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed table-driven bench for ctrl_sequencer
// (default parameters, sign-extended immediate).
module tb_ctrl_sequencer;
   import ctrl_pkg::*;

   typedef struct packed {
      logic [5:0]  st;
      logic [5:0]  stb;   // {MAR, IR, MDR, REG, RAM, INCR_PC}
      logic [2:0]  r0, r1, ws;
      logic [1:0]  mdrs, op0, op1;
      logic        h, il;
      logic [15:0] imm;
   } obs_t;

   typedef struct {
      string       name;
      logic        rst;
      logic [15:0] instr;
      logic        mr;
      obs_t        exp;
   } vec_t;

   // Instruction words: {op[15:13], imm/ra/rb, tgt[2:0]}
   localparam logic [15:0] I_LDI = 16'hBFFB; // LDI imm=3FF tgt=3
   localparam logic [15:0] I_ALU = 16'h0054; // ALU ra=1 rb=2 tgt=4
   localparam logic [15:0] I_LD  = 16'h2142; // LD  ra=5 tgt=2
   localparam logic [15:0] I_ST  = 16'h4181; // ST  ra=6 tgt=1
   localparam logic [15:0] I_BAD = 16'h6000; // opcode 011
   localparam logic [15:0] I_HLT = 16'hE000;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   reset = 1'b1;
   state_t dbg_state;
   always #5 clk = ~clk;

   ctrl_sequencer_if #(.IW(16), .RSW(3), .DW(16)) bus ();

   ctrl_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.master),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   vec_t vecs[$];

   function automatic obs_t mk(logic [5:0] st, logic [5:0] stb, logic [2:0] r0,
                               logic [2:0] r1, logic [2:0] ws, logic [1:0] mdrs,
                               logic [1:0] op0, logic [1:0] op1, logic h,
                               logic il, logic [15:0] imm);
      obs_t o;
      o.st = st; o.stb = stb; o.r0 = r0; o.r1 = r1; o.ws = ws;
      o.mdrs = mdrs; o.op0 = op0; o.op1 = op1; o.h = h; o.il = il; o.imm = imm;
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.st   = dbg_state;
      o.stb  = {bus.MAR_LOAD, bus.IR_LOAD, bus.MDR_LOAD, bus.REG_LOAD,
                bus.RAM_LOAD, bus.INCR_PC};
      o.r0   = bus.REGR0S; o.r1 = bus.REGR1S; o.ws = bus.REGWS;
      o.mdrs = bus.MDRS; o.op0 = bus.OP0S; o.op1 = bus.OP1S;
      o.h    = bus.halted; o.il = bus.illegal; o.imm = bus.IRimm;
      return o;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic add(string nm, logic rst, logic [15:0] ins, logic mr, obs_t e);
      vec_t v;
      v.name = nm; v.rst = rst; v.instr = ins; v.mr = mr; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic drive(logic rst, logic [15:0] ins, logic mr);
      @(negedge clk);
      reset = rst; bus.instr = ins; bus.mem_ready = mr;
      #1;
   endtask

   task automatic check(string nm, obs_t exp);
      obs_t got;
      got = observe();
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got st=%b stb=%b r0=%0d r1=%0d ws=%0d mdrs=%0d op0=%0d op1=%0d h=%b il=%b imm=%h | exp st=%b stb=%b r0=%0d r1=%0d ws=%0d mdrs=%0d op0=%0d op1=%0d h=%b il=%b imm=%h",
                  nm, got.st, got.stb, got.r0, got.r1, got.ws, got.mdrs, got.op0,
                  got.op1, got.h, got.il, got.imm, exp.st, exp.stb, exp.r0, exp.r1,
                  exp.ws, exp.mdrs, exp.op0, exp.op1, exp.h, exp.il, exp.imm);
      end
   endtask

   initial begin
      bus.instr = I_LDI; bus.mem_ready = 1'b1;

      // ---------------- vector table ----------------
      add("reset_hold",   1, I_LDI, 1, mk(ST_FETCH,    6'b000000, 0,0,0, 0,0,0, 0,0, 16'hFFFF));
      add("fetch_stall",  0, I_LDI, 0, mk(ST_FETCH,    6'b100000, 0,7,0, 0,0,1, 0,0, 16'hFFFF));
      add("ldi_fetch",    0, I_LDI, 1, mk(ST_FETCH,    6'b110001, 0,7,0, 0,0,1, 0,0, 16'hFFFF));
      add("ldi_decode",   0, I_LDI, 1, mk(ST_DECODE,   6'b001000, 0,0,0, 0,0,0, 0,0, 16'hFFFF));
      add("ldi_exec",     0, I_LDI, 1, mk(ST_EXEC,     6'b000100, 0,0,3, 0,2,0, 0,0, 16'hFFFF));
      add("alu_fetch",    0, I_ALU, 1, mk(ST_FETCH,    6'b110001, 0,7,0, 0,0,1, 0,0, 16'h0000));
      add("alu_decode",   0, I_ALU, 1, mk(ST_DECODE,   6'b000000, 1,2,0, 0,0,1, 0,0, 16'h0000));
      add("alu_read",     0, I_ALU, 1, mk(ST_READ,     6'b001000, 1,2,0, 2,0,1, 0,0, 16'h0000));
      add("alu_exec",     0, I_ALU, 1, mk(ST_EXEC,     6'b000100, 0,0,4, 0,2,0, 0,0, 16'h0000));
      add("ld_fetch",     0, I_LD,  1, mk(ST_FETCH,    6'b110001, 0,7,0, 0,0,1, 0,0, 16'h0000));
      add("ld_decode",    0, I_LD,  1, mk(ST_DECODE,   6'b100000, 5,0,0, 0,0,0, 0,0, 16'h0000));
      add("ld_read_wait", 0, I_LD,  0, mk(ST_READ,     6'b000000, 0,0,0, 1,0,0, 0,0, 16'h0000));
      add("ld_wait1",     0, I_LD,  0, mk(ST_WAIT_MEM, 6'b000000, 0,0,0, 1,0,0, 0,0, 16'h0000));
      add("ld_wait2",     0, I_LD,  0, mk(ST_WAIT_MEM, 6'b000000, 0,0,0, 1,0,0, 0,0, 16'h0000));
      add("ld_wait_done", 0, I_LD,  1, mk(ST_WAIT_MEM, 6'b001000, 0,0,0, 1,0,0, 0,0, 16'h0000));
      add("ld_exec",      0, I_LD,  1, mk(ST_EXEC,     6'b000100, 0,0,2, 0,2,0, 0,0, 16'h0000));
      add("st_fetch",     0, I_ST,  1, mk(ST_FETCH,    6'b110001, 0,7,0, 0,0,1, 0,0, 16'h0000));
      add("st_decode",    0, I_ST,  1, mk(ST_DECODE,   6'b100000, 6,0,0, 0,0,0, 0,0, 16'h0000));
      add("st_read",      0, I_ST,  1, mk(ST_READ,     6'b001000, 1,0,0, 2,0,0, 0,0, 16'h0000));
      add("st_exec_w1",   0, I_ST,  0, mk(ST_EXEC,     6'b000010, 0,0,0, 0,0,0, 0,0, 16'h0000));
      add("st_exec_w2",   0, I_ST,  0, mk(ST_EXEC,     6'b000010, 0,0,0, 0,0,0, 0,0, 16'h0000));
      add("st_exec_done", 0, I_ST,  1, mk(ST_EXEC,     6'b000010, 0,0,0, 0,0,0, 0,0, 16'h0000));
      add("bad_fetch",    0, I_BAD, 1, mk(ST_FETCH,    6'b110001, 0,7,0, 0,0,1, 0,0, 16'h0000));
      add("bad_decode",   0, I_BAD, 1, mk(ST_DECODE,   6'b000000, 0,0,0, 0,0,0, 0,1, 16'h0000));
      add("hlt_fetch",    0, I_HLT, 1, mk(ST_FETCH,    6'b110001, 0,7,0, 0,0,1, 0,0, 16'h0000));
      add("hlt_decode",   0, I_HLT, 1, mk(ST_DECODE,   6'b000000, 0,0,0, 0,0,0, 0,0, 16'h0000));
      add("hlt_enter",    0, I_HLT, 1, mk(ST_HALT,     6'b000000, 0,0,0, 0,0,0, 1,0, 16'h0000));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].instr, vecs[i].mr);
         check(vecs[i].name, vecs[i].exp);
      end

      // ---------------- HALT is sticky while mem_ready toggles ----------------
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, I_HLT, i[0]);
         check("halt_hold", mk(ST_HALT, 6'b000000, 0,0,0, 0,0,0, 1,0, 16'h0000));
      end

      // ---------------- asynchronous reset in the middle of LD EXEC ----------------
      drive(1'b1, I_LD, 1'b1);
      check("halt_reset", mk(ST_FETCH, 6'b000000, 0,0,0, 0,0,0, 0,0, 16'h0000));
      drive(1'b0, I_LD, 1'b1);
      check("rst_ld_fetch",  mk(ST_FETCH,  6'b110001, 0,7,0, 0,0,1, 0,0, 16'h0000));
      drive(1'b0, I_LD, 1'b1);
      check("rst_ld_decode", mk(ST_DECODE, 6'b100000, 5,0,0, 0,0,0, 0,0, 16'h0000));
      drive(1'b0, I_LD, 1'b1);
      check("rst_ld_read",   mk(ST_READ,   6'b001000, 0,0,0, 1,0,0, 0,0, 16'h0000));
      drive(1'b0, I_LD, 1'b1);
      check("rst_ld_exec",   mk(ST_EXEC,   6'b000100, 0,0,2, 0,2,0, 0,0, 16'h0000));
      #1 reset = 1'b1;
      #1;
      check("rst_mid_exec",  mk(ST_FETCH,  6'b000000, 0,0,0, 0,0,0, 0,0, 16'h0000));
      drive(1'b0, I_LD, 1'b1);
      check("rst_release",   mk(ST_FETCH,  6'b110001, 0,7,0, 0,0,1, 0,0, 16'h0000));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
